// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   state_t        loader FSM states
//   SYNC_BYTE_DEF  default frame start marker
//   HDR_LEN        bytes in the frame header (sync + two length bytes)
//   LEN_W          width of the frame length field
package instr_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         HDR_LEN       = 3;
  localparam int         LEN_W         = 16;

endpackage

// File: rtl/instr_loader_timer.sv
// Inter-byte idle timer: a clearable counter that saturates at TIMEOUT_CYC.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_clr      clear the count (byte accepted, or timer not in use)
//   i_run      count this cycle
//   o_expired  count has reached TIMEOUT_CYC
module instr_loader_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction loader. Accepts a framed byte stream
// (SYNC, LEN_HI, LEN_LO, 4*N data bytes MSB first, XOR checksum), writes
// big-endian words into the instruction RAM from address 0 and holds the
// core until a frame with a correct checksum has been loaded.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready byte stream from the UART receiver
//   start                     re-arm pulse from DONE or ERROR
//   imem_we/addr/wdata        instruction RAM write port
//   cpu_hold                  1 while the core must stay held
//   load_done, load_err       frame result levels
//   word_cnt                  words written in the current frame
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [23:0]        r_shift;
  logic [1:0]         r_byte_idx;
  logic [7:0]         r_csum;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [ADDR_W:0]    r_word_cnt;

  logic               w_accept;
  logic               w_expired;
  logic               w_tmr_run;
  logic               w_rearm;
  logic [LEN_W-1:0]   w_len_n;
  logic               w_oversize;
  logic [31:0]        w_word;
  logic [ADDR_W:0]    w_cnt_inc;
  logic               w_last_word;

  assign w_accept    = rx_valid && rx_ready;
  assign w_rearm     = ((r_state == DONE) || (r_state == ERROR)) && start;
  assign w_len_n     = {r_len[LEN_W-1:8], rx_data};
  assign w_oversize  = 32'(w_len_n) > (32'd1 << ADDR_W);
  assign w_word      = {r_shift, rx_data};
  assign w_cnt_inc   = r_word_cnt + (ADDR_W+1)'(1);
  assign w_last_word = (r_byte_idx == 2'd3) && (32'(w_cnt_inc) == 32'(r_len));

  // The timer only runs while a frame is in progress; holding it clear
  // otherwise means every frame starts with a fresh idle budget.
  instr_loader_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept || !w_tmr_run),
    .i_run     (w_tmr_run),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_SYNC;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; an accepted byte always takes priority over a timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_SYNC: if (w_accept && (rx_data == SYNC_BYTE)) w_next = LEN_HI;
      LEN_HI: begin
        if (w_accept)       w_next = LEN_LO;
        else if (w_expired) w_next = ERROR;
      end
      LEN_LO: begin
        if (w_accept) begin
          if (w_oversize)           w_next = ERROR;
          else if (w_len_n == '0)   w_next = CHECK;
          else                      w_next = DATA;
        end else if (w_expired) begin
          w_next = ERROR;
        end
      end
      DATA: begin
        if (w_accept) begin
          if (w_last_word) w_next = CHECK;
        end else if (w_expired) begin
          w_next = ERROR;
        end
      end
      CHECK: begin
        if (w_accept)       w_next = (rx_data == r_csum) ? DONE : ERROR;
        else if (w_expired) w_next = ERROR;
      end
      DONE, ERROR: if (start) w_next = WAIT_SYNC;
      default: w_next = WAIT_SYNC;
    endcase
  end

  // Output decode
  always_comb begin
    rx_ready  = 1'b0;
    w_tmr_run = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (r_state)
      WAIT_SYNC:                 rx_ready = 1'b1;
      LEN_HI, LEN_LO, DATA, CHECK: begin
        rx_ready  = 1'b1;
        w_tmr_run = 1'b1;
      end
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      ERROR:   load_err = 1'b1;
      default: ;
    endcase
  end

  // Frame bookkeeping and the registered RAM write port. The write for a
  // word lands one cycle after its 4th byte, and word_cnt moves with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
      r_byte_idx <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_rearm) begin
        r_word_cnt <= '0;
        r_csum     <= '0;
        r_byte_idx <= '0;
      end
      if (w_accept && (r_state == DATA)) begin
        r_csum     <= r_csum ^ rx_data;
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_we       <= 1'b1;
          r_addr     <= r_word_cnt[ADDR_W-1:0];
          r_wdata    <= w_word;
          r_word_cnt <= w_cnt_inc;
        end
      end
    end
  end

  // Length capture and word assembly need no reset: they are always
  // rewritten before use within a frame.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_state == LEN_HI) r_len[LEN_W-1:8] <= rx_data;
      if (r_state == LEN_LO) r_len            <= w_len_n;
      if (r_state == DATA)   r_shift          <= w_word[23:0];
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_cnt   = r_word_cnt;

endmodule
